// File: rtl/block_map_rd_arbiter.sv
// ---------------------------------------------------------------------------
// block_map_rd_arbiter
//
// Round-robin arbiter that shares the single synchronous read port of the
// block map RAM among N_REQ requesters (bomberman movement, enemy direction
// checkers, explosion spread).  One RAM read is issued per cycle; each read
// carries a tag through a delay line matched to the RAM latency so the data
// is returned to the requester that asked for it.
//
// Ports
//   clk_i        system clock, all logic on the rising edge
//   reset_i      synchronous active-high reset
//   clear_i      synchronous flush: drops all outstanding reads, keeps ptr
//   req_i        per-requester read request (level)
//   req_addr_i   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt_o        one-hot pulse, requester's address accepted
//   rd_valid_o   one-hot pulse, rd_data_o belongs to this requester
//   rd_data_o    read data, zero when no rd_valid_o bit is set
//   busy_o       requester has a read outstanding
//   ram_en_o     RAM read enable
//   ram_addr_o   RAM read address
//   ram_dout_i   RAM read data, RD_LAT cycles after the sampling edge
// ---------------------------------------------------------------------------
module block_map_rd_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 2,
  parameter int RD_LAT = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      clear_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          rd_valid_o,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic [N_REQ-1:0]          busy_o,
  output logic                      ram_en_o,
  output logic [ADDR_W-1:0]         ram_addr_o,
  input  logic [DATA_W-1:0]         ram_dout_i
);

  localparam int PTR_W   = $clog2(N_REQ);
  localparam int TAG_LEN = RD_LAT + 1;

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rd_valid_q, rd_valid_d;
  logic [N_REQ-1:0]  busy_q, busy_d;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [TAG_LEN-1:0] tag_vld_q, tag_vld_d;
  logic [PTR_W-1:0]  tag_idx_q [TAG_LEN];
  logic [PTR_W-1:0]  tag_idx_d [TAG_LEN];

  logic [N_REQ-1:0]  eligible;
  logic              win_valid;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W:0]    cand_sum;
  logic [PTR_W-1:0]  cand;
  logic [ADDR_W-1:0] addr_sel;

  // Round-robin search starting at ptr; a requester whose previous read is
  // still outstanding is masked by its busy bit.
  always_comb begin
    eligible  = req_i & ~busy_q;
    win_valid = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand_sum >= (PTR_W+1)'(N_REQ)) begin
        cand_sum = cand_sum - (PTR_W+1)'(N_REQ);
      end
      cand = cand_sum[PTR_W-1:0];
      if (!win_valid && eligible[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    addr_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_idx == PTR_W'(k)) begin
        addr_sel = req_addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    gnt_d      = '0;
    ram_en_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ptr_d      = ptr_q;
    // busy drops at the edge that ends the rd_valid cycle
    busy_d     = busy_q & ~rd_valid_q;
    tag_vld_d  = {tag_vld_q[TAG_LEN-2:0], 1'b0};
    tag_idx_d[0] = win_idx;
    for (int k = 1; k < TAG_LEN; k++) begin
      tag_idx_d[k] = tag_idx_q[k-1];
    end
    rd_valid_d = tag_vld_q[TAG_LEN-1] ? onehot(tag_idx_q[TAG_LEN-1]) : '0;

    if (clear_i) begin
      busy_d     = '0;
      tag_vld_d  = '0;
      rd_valid_d = '0;
    end else if (win_valid) begin
      gnt_d        = onehot(win_idx);
      ram_en_d     = 1'b1;
      ram_addr_d   = addr_sel;
      ptr_d        = (win_idx == PTR_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
      busy_d       = busy_d | onehot(win_idx);
      tag_vld_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      gnt_q      <= '0;
      rd_valid_q <= '0;
      busy_q     <= '0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      ptr_q      <= '0;
      tag_vld_q  <= '0;
      for (int k = 0; k < TAG_LEN; k++) begin
        tag_idx_q[k] <= '0;
      end
    end else begin
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      ptr_q      <= ptr_d;
      tag_vld_q  <= tag_vld_d;
      for (int k = 0; k < TAG_LEN; k++) begin
        tag_idx_q[k] <= tag_idx_d[k];
      end
    end
  end

  assign gnt_o      = gnt_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = busy_q;
  assign ram_en_o   = ram_en_q;
  assign ram_addr_o = ram_addr_q;
  // RAM data is only meaningful in the cycle a tag emerges
  assign rd_data_o  = (|rd_valid_q) ? ram_dout_i : '0;

endmodule
